// File: rtl/ahb_pkg.sv
// Shared AHB5 encodings, FSM state type and byte-lane/alignment helpers
// used by the SRAM slave and its exclusive monitor.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} ahb_state_t;

  // Byte b is enabled when it sits in the same size-aligned chunk as the address.
  function automatic logic [7:0] ahb_byte_mask(input logic [2:0] size, input logic [2:0] addr_lsbs,
                                               input int w_data);
    int lsb;
    ahb_byte_mask = '0;
    lsb = int'(addr_lsbs) & (w_data / 8 - 1);
    for (int b = 0; b < 8; b++)
      if (b < w_data / 8 && (b >> size) == (lsb >> size)) ahb_byte_mask[b] = 1'b1;
  endfunction

  function automatic logic ahb_aligned(input logic [2:0] size, input logic [2:0] addr);
    return (int'(addr) & ((1 << size) - 1)) == 0;
  endfunction
endpackage

// File: rtl/ahb_excl_monitor.sv
// Single-reservation exclusive monitor: {valid, master, word index}.
// pass is combinational against the transfer currently in its data phase.
module ahb_excl_monitor #(
  parameter int W_IDX = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             clr,
  input  logic [7:0]       master,
  input  logic [W_IDX-1:0] idx,
  output logic             pass
);
  logic             valid;
  logic [7:0]       res_master;
  logic [W_IDX-1:0] res_idx;

  assign pass = valid && res_master == master && res_idx == idx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid      <= 1'b0;
      res_master <= '0;
      res_idx    <= '0;
    end else if (set) begin
      valid      <= 1'b1;
      res_master <= master;
      res_idx    <= idx;
    end else if (clr && idx == res_idx) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/ahb5_sram_slave.sv
// AHB5 SRAM slave: word array with byte-lane writes, programmable wait states,
// two-cycle ERROR responses and an exclusive-access monitor driving hexokay.
module ahb5_sram_slave
  import ahb_pkg::*;
#(
  parameter int                 W_ADDR      = 32,
  parameter int                 W_DATA      = 32,
  parameter int                 DEPTH       = 4096,
  parameter int                 WAIT_STATES = 0,
  parameter logic [W_ADDR-1:0]  BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [W_ADDR-1:0] haddr,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hexcl,
  input  logic [7:0]        hmaster,
  input  logic              hready,
  input  logic [W_DATA-1:0] hwdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              hexokay,
  output logic [W_DATA-1:0] hrdata
);
  localparam int BYTES = W_DATA / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [W_ADDR:0] SIZE_B = (W_ADDR + 1)'(DEPTH * BYTES);

  ahb_state_t      state;
  logic [3:0]      cnt;
  logic            live;
  logic            fault_q, write_q, excl_q;
  logic [2:0]      size_q, lsb_q;
  logic [7:0]      master_q;
  logic [AW-1:0]   idx_q;

  logic            acc, fault, done, pass, wr_en, rd_go;
  logic [W_ADDR:0] offs;
  logic [AW-1:0]   addr_idx, rd_idx;
  logic [BYTES-1:0] be;
  logic [W_DATA-1:0] rd_word;
  logic [W_DATA-1:0] mem [DEPTH];

  assign acc      = hsel && hready && htrans != HTRANS_IDLE && htrans != HTRANS_BUSY;
  assign offs     = {1'b0, haddr} - {1'b0, BASE_ADDR};
  assign addr_idx = offs[LB +: AW];
  assign fault    = offs >= SIZE_B || !ahb_aligned(hsize, haddr[2:0]) || hsize > 3'(LB);

  // live marks a non-faulted data phase; it completes whenever hreadyout is high.
  assign done    = live && hreadyout;
  assign be      = BYTES'(ahb_byte_mask(size_q, lsb_q, W_DATA));
  assign wr_en   = done && write_q && (!excl_q || pass);
  assign hexokay = done && excl_q && (!write_q || pass);

  ahb_excl_monitor #(.W_IDX(AW)) u_excl (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (done && excl_q && !write_q),
    .clr    (wr_en),
    .master (master_q),
    .idx    (idx_q),
    .pass   (pass)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      live      <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      fault_q   <= 1'b0;
      write_q   <= 1'b0;
      excl_q    <= 1'b0;
      size_q    <= '0;
      lsb_q     <= '0;
      master_q  <= '0;
      idx_q     <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (fault_q) begin
              state <= ST_ERR1;
              hresp <= HRESP_ERROR;
            end else begin
              state     <= ST_IDLE;
              hreadyout <= 1'b1;
              live      <= 1'b1;
            end
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
        end
        default: begin
          // IDLE and ERR2 both present hreadyout=1, so a new address phase may land here
          state <= ST_IDLE;
          live  <= 1'b0;
          hresp <= HRESP_OKAY;
          if (acc) begin
            fault_q  <= fault;
            write_q  <= hwrite;
            excl_q   <= hexcl;
            size_q   <= hsize;
            lsb_q    <= haddr[2:0];
            master_q <= hmaster;
            idx_q    <= addr_idx;
            if (WAIT_STATES != 0) begin
              state     <= ST_WAIT;
              cnt       <= 4'(WAIT_STATES);
              hreadyout <= 1'b0;
            end else if (fault) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= HRESP_ERROR;
            end else begin
              live <= 1'b1;
            end
          end
        end
      endcase
    end

  always_comb begin
    rd_go  = 1'b0;
    rd_idx = idx_q;
    if (WAIT_STATES == 0) begin
      rd_go  = acc && hreadyout && !fault && !hwrite;
      rd_idx = addr_idx;
    end else begin
      rd_go = state == ST_WAIT && cnt == 4'd1 && !fault_q && !write_q;
    end
    rd_word = mem[rd_idx];
    // a write to the same word completing on this edge is forwarded into the read
    for (int b = 0; b < BYTES; b++)
      if (wr_en && be[b] && idx_q == rd_idx) rd_word[8*b +: 8] = hwdata[8*b +: 8];
  end

  always_ff @(posedge clk)
    if (wr_en)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hrdata <= '0;
    else if (rd_go) hrdata <= rd_word;
endmodule

// File: tb/tb_ahb5_sram_slave.sv
// Bench for ahb5_sram_slave: a zero-wait and a 3-wait instance share one bus,
// driven by a pipelined master and checked against a word/reservation model.
module tb_ahb5_sram_slave;
  import ahb_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel0, hsel3, hwrite, hexcl, hready, cur;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [7:0]  hmaster;
  logic        ro0, rsp0, xo0, ro3, rsp3, xo3;
  logic [31:0] rd0, rd3;

  always #5 clk = ~clk;
  assign hready = cur ? ro3 : ro0;

  ahb5_sram_slave #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hexcl(hexcl), .hmaster(hmaster), .hready(hready), .hwdata(hwdata),
    .hreadyout(ro0), .hresp(rsp0), .hexokay(xo0), .hrdata(rd0));

  ahb5_sram_slave #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel3), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hexcl(hexcl), .hmaster(hmaster), .hready(hready), .hwdata(hwdata),
    .hreadyout(ro3), .hresp(rsp3), .hexokay(xo3), .hrdata(rd3));

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic        ex;
    logic [7:0]  m;
    logic [31:0] wd;
  } tr_t;

  tr_t         q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mm [int];
  logic        res_v [2];
  logic [7:0]  res_m [2];
  int          res_w [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic ex,
                      input logic [7:0] m, input logic [31:0] wd);
    tr_t t;
    t.addr = a; t.wr = wr; t.size = sz; t.ex = ex; t.m = m; t.wd = wd;
    q.push_back(t);
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE; haddr = '0;
    hwrite = 1'b0; hexcl = 1'b0; hsize = HSIZE_WORD; hmaster = '0;
  endtask

  task automatic drive(input tr_t t, input int d);
    hsel0 = (d == 0); hsel3 = (d == 1); htrans = HTRANS_NONSEQ; haddr = t.addr;
    hwrite = t.wr; hexcl = t.ex; hsize = t.size; hmaster = t.m;
  endtask

  // Expected behaviour of one finished transfer, from the slave's documented rules.
  task automatic complete(input tr_t t, input int d, input int lows, input logic llr,
                          input logic rsp, input logic xo, input logic [31:0] rd);
    logic err, pass, exp_xo;
    int k, off;
    logic [31:0] w;
    err = t.addr >= DEPTH * 4 || t.size > HSIZE_WORD || (t.addr % (32'd1 << t.size)) != 0;
    k = d * 65536 + int'(t.addr / 4);
    off = int'(t.addr % 4);
    exp_xo = 1'b0;
    chk("wait_cycles", 32'(lows), 32'((d == 1 ? 3 : 0) + int'(err)));
    chk("hresp_final", 32'(rsp), 32'(err));
    if (lows > 0) chk("hresp_last_stall", 32'(llr), 32'(err));
    if (!err) begin
      if (!t.wr) begin
        if (mm.exists(k)) chk("hrdata", rd, mm[k]);
        if (t.ex) begin res_v[d] = 1'b1; res_m[d] = t.m; res_w[d] = k; exp_xo = 1'b1; end
      end else begin
        pass = res_v[d] && res_m[d] == t.m && res_w[d] == k;
        if (!t.ex || pass) begin
          if (mm.exists(k) || t.size == HSIZE_WORD) begin
            w = mm.exists(k) ? mm[k] : 32'h0;
            for (int b = 0; b < (1 << t.size); b++) w[8*(off+b) +: 8] = t.wd[8*(off+b) +: 8];
            mm[k] = w;
          end
          if (res_v[d] && res_w[d] == k) res_v[d] = 1'b0;
          exp_xo = t.ex;
        end
      end
    end
    chk("hexokay", 32'(xo), 32'(exp_xo));
  endtask

  // Pipelined master: next address phase overlaps the current data phase.
  task automatic run(input int d);
    int ap, dp, lows, guard;
    logic llr, rdy;
    ap = 0; dp = -1; lows = 0; llr = 1'b0; guard = 0; cur = (d == 1);
    while ((ap < q.size() || dp >= 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
      rdy = d == 1 ? ro3 : ro0;
      if (dp >= 0) begin
        hwdata = q[dp].wd;
        if (rdy) begin
          complete(q[dp], d, lows, llr, d == 1 ? rsp3 : rsp0, d == 1 ? xo3 : xo0, d == 1 ? rd3 : rd0);
          dp = -1; lows = 0; llr = 1'b0;
        end else begin
          lows++;
          llr = d == 1 ? rsp3 : rsp0;
          chk("hexokay_stalled", 32'(d == 1 ? xo3 : xo0), 32'h0);
        end
      end
      if (ap < q.size()) begin
        drive(q[ap], d);
        if (rdy) begin dp = ap; ap++; end
      end else begin
        bus_idle();
      end
    end
    chk("drained", 32'(guard < 2000), 32'h1);
    q.delete();
  endtask

  task automatic directed(input int d);
    push(32'h40, 1, HSIZE_WORD, 0, 1, 32'hDEADBEEF);
    push(32'h40, 0, HSIZE_WORD, 0, 1, 0);
    push(32'h80, 1, HSIZE_WORD, 0, 1, 32'h11223344);
    push(32'h82, 1, HSIZE_BYTE, 0, 1, 32'h00AA0000);
    push(32'h80, 0, HSIZE_WORD, 0, 1, 0);
    push(DEPTH * 4, 0, HSIZE_WORD, 0, 1, 0);
    push(32'h40, 0, HSIZE_WORD, 0, 1, 0);
    push(32'h41, 1, HSIZE_HALF, 0, 1, 32'hFFFFFFFF);
    push(32'h40, 0, HSIZE_WORD, 0, 1, 0);
    push(32'h40, 0, HSIZE_DWORD, 0, 1, 0);
    push(32'h100, 1, HSIZE_WORD, 0, 1, 32'h0);
    push(32'h100, 0, HSIZE_WORD, 1, 1, 0);
    push(32'h100, 1, HSIZE_WORD, 1, 1, 32'h12345678);
    push(32'h100, 1, HSIZE_WORD, 1, 1, 32'h99999999);
    push(32'h100, 0, HSIZE_WORD, 0, 1, 0);
    push(32'h100, 0, HSIZE_WORD, 1, 1, 0);
    push(32'h100, 1, HSIZE_WORD, 0, 2, 32'h0000ABCD);
    push(32'h100, 1, HSIZE_WORD, 1, 1, 32'h77777777);
    push(32'h100, 0, HSIZE_WORD, 0, 1, 0);
    push(32'h100, 0, HSIZE_WORD, 1, 1, 0);
    push(32'h100, 0, HSIZE_WORD, 1, 2, 0);
    push(32'h100, 1, HSIZE_WORD, 1, 1, 32'h11111111);
    push(32'h100, 1, HSIZE_WORD, 1, 2, 32'h22222222);
    push(32'h100, 0, HSIZE_WORD, 0, 1, 0);
    run(d);
  endtask

  initial begin
    tr_t t;
    bus_idle();
    hwdata = '0; cur = 1'b0;
    res_v[0] = 1'b0; res_v[1] = 1'b0;
    res_m[0] = '0; res_m[1] = '0; res_w[0] = 0; res_w[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_hreadyout0", 32'(ro0), 32'h1);
    chk("rst_hresp0", 32'(rsp0), 32'h0);
    chk("rst_hexokay0", 32'(xo0), 32'h0);
    chk("rst_hrdata0", rd0, 32'h0);
    chk("rst_hreadyout3", 32'(ro3), 32'h1);
    chk("rst_hresp3", 32'(rsp3), 32'h0);
    chk("rst_hexokay3", 32'(xo3), 32'h0);
    chk("rst_hrdata3", rd3, 32'h0);
    rst_n = 1'b1;

    directed(0);
    directed(1);

    // reset during the wait states of a write on the 3-wait slave
    push(32'h104, 1, HSIZE_WORD, 0, 1, 32'h01040104);
    push(32'h100, 0, HSIZE_WORD, 1, 1, 0);
    run(1);
    t.addr = 32'h104; t.wr = 1'b1; t.size = HSIZE_WORD; t.ex = 1'b0; t.m = 8'd1; t.wd = 32'h55555555;
    @(negedge clk);
    drive(t, 1);
    @(negedge clk);
    bus_idle();
    hwdata = t.wd;
    chk("wait_low_before_reset", 32'(ro3), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hreadyout", 32'(ro3), 32'h1);
    chk("midrst_hresp", 32'(rsp3), 32'h0);
    chk("midrst_hexokay", 32'(xo3), 32'h0);
    chk("midrst_hrdata", rd3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    res_v[0] = 1'b0; res_v[1] = 1'b0;
    push(32'h100, 1, HSIZE_WORD, 1, 1, 32'h0BAD0BAD);
    push(32'h100, 0, HSIZE_WORD, 0, 1, 0);
    push(32'h104, 0, HSIZE_WORD, 0, 1, 0);
    run(1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) push(32'h200 + 32'(4 * i), 1, HSIZE_WORD, 0, 1, $urandom);
      run(d);
      for (int i = 0; i < 60; i++) begin
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
        else a = 32'h200 + 32'($urandom_range(0, 63));
        push(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
             8'($urandom_range(1, 2)), $urandom);
      end
      run(d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
